// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result valid-ready bus for the pipelined add/subtract unit
interface pipelined_addsub_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;
  modport master(output in_valid, a, b, cin, sub, out_ready,
                 input in_ready, out_valid, sum, cout, ovf);
  modport slave(input in_valid, a, b, cin, sub, out_ready,
                output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: sliced ripple-carry add/subtract, one slice per stage, global-stall handshake
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic reset,
  pipelined_addsub_if.slave bus
);
  localparam int W = WIDTH / STAGES;
  logic adv, fire, c_eff, ovf_q;
  logic [WIDTH-1:0] b_eff;
  function automatic logic [W:0] ripple(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W-1:0] s;
    logic c;
    s = '0;
    c = ci;
    for (int i = 0; i < W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (y[i] & c) | (x[i] & c);
    end
    return {c, s};
  endfunction
  assign adv   = !bus.out_valid || bus.out_ready;
  assign fire  = bus.in_valid && bus.in_ready;
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? ~bus.cin : bus.cin;
  // Stage k holds the finished low (k+1)*W result bits plus the operand bits still to be consumed
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [W-1:0] x, y;
    logic [W:0] r;
    logic [(k+1)*W-1:0] s_d, s_q;
    logic ci, vi, v_q, c_q;
    if (k == 0) begin : g_in
      assign x   = bus.a[W-1:0];
      assign y   = b_eff[W-1:0];
      assign ci  = c_eff;
      assign vi  = fire;
      assign s_d = r[W-1:0];
    end else begin : g_in
      assign x   = g_st[k-1].g_fw.a_q[W-1:0];
      assign y   = g_st[k-1].g_fw.b_q[W-1:0];
      assign ci  = g_st[k-1].c_q;
      assign vi  = g_st[k-1].v_q;
      assign s_d = {r[W-1:0], g_st[k-1].s_q};
    end
    assign r = ripple(x, y, ci);
    // Data only moves with a valid beat so outputs read 0 until the first real result
    always_ff @(posedge clk)
      if (reset) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= vi;
        if (vi) begin
          s_q <= s_d;
          c_q <= r[W];
        end
      end
    if (k < STAGES - 1) begin : g_fw
      localparam int UW = WIDTH - (k + 1) * W;
      logic [UW-1:0] a_d, b_d, a_q, b_q;
      if (k == 0) begin : g_src
        assign a_d = bus.a[WIDTH-1:W];
        assign b_d = b_eff[WIDTH-1:W];
      end else begin : g_src
        assign a_d = g_st[k-1].g_fw.a_q[UW+W-1:W];
        assign b_d = g_st[k-1].g_fw.b_q[UW+W-1:W];
      end
      always_ff @(posedge clk)
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vi) begin
          a_q <= a_d;
          b_q <= b_d;
        end
    end
  end
  always_ff @(posedge clk)
    if (reset) ovf_q <= 1'b0;
    else if (adv && g_st[STAGES-1].vi)
      ovf_q <= (g_st[STAGES-1].x[W-1] == g_st[STAGES-1].y[W-1]) &&
               (g_st[STAGES-1].r[W-1] != g_st[STAGES-1].x[W-1]);
  assign bus.in_ready  = adv && !reset;
  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.sum       = g_st[STAGES-1].s_q;
  assign bus.cout      = g_st[STAGES-1].c_q;
  assign bus.ovf       = ovf_q;
endmodule
